// File: rtl/hv_timing_gen.sv
// rtl/hv_timing_gen.sv - horizontal/vertical video timing generator with blanking, syncs and RGB gating
// Optional frame-latched position mirroring is enabled by defining HVTG_FLIP_EN.
module hv_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 20,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 44,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 22,
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int DW       = 12,
  parameter int SYNC_POL = 0
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          CE,
  input  logic [DW-1:0] RGB_IN,
`ifdef HVTG_FLIP_EN
  input  logic          FLIP,
`endif
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBLK,
  output logic          VBLK,
  output logic          DE,
  output logic          HSYN,
  output logic          VSYN,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [DW-1:0] RGB_OUT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  generate
    if (H_TOTAL > 2**HW) begin : g_h_too_wide
      $error("hv_timing_gen: H_TOTAL does not fit in HW bits");
    end
    if (V_TOTAL > 2**VW) begin : g_v_too_wide
      $error("hv_timing_gen: V_TOTAL does not fit in VW bits");
    end
  endgenerate

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hblk_q, hblk_d, vblk_q, vblk_d, de_q, de_d;
  logic          hsyn_q, hsyn_d, vsyn_q, vsyn_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic [DW-1:0] rgb_q, rgb_d;

  // Every flag is computed from the next position so it lands on the same edge as the counter.
  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    hblk_d = (h_d >= H_ACT);
    vblk_d = (v_d >= V_ACT);
    de_d   = ~hblk_d & ~vblk_d;
    hsyn_d = (h_d >= HS_ON && h_d < HS_OFF) ? SYNC_ACT : ~SYNC_ACT;
    vsyn_d = (v_d >= VS_ON && v_d < VS_OFF) ? SYNC_ACT : ~SYNC_ACT;
    ls_d   = (h_d == '0);
    fs_d   = ls_d && (v_d == '0);
    rgb_d  = de_d ? RGB_IN : '0;
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q    <= H_LAST;
      v_q    <= V_LAST;
      hblk_q <= 1'b1;
      vblk_q <= 1'b1;
      de_q   <= 1'b0;
      hsyn_q <= ~SYNC_ACT;
      vsyn_q <= ~SYNC_ACT;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (CE) begin
        h_q    <= h_d;
        v_q    <= v_d;
        hblk_q <= hblk_d;
        vblk_q <= vblk_d;
        de_q   <= de_d;
        hsyn_q <= hsyn_d;
        vsyn_q <= vsyn_d;
        ls_q   <= ls_d;
        fs_q   <= fs_d;
        rgb_q  <= rgb_d;
      end
    end
  end

`ifdef HVTG_FLIP_EN
  logic          flip_q, flip_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;

  // The new FLIP value already applies to the frame-start pixel itself.
  always_comb begin
    flip_d = fs_d ? FLIP : flip_q;
    hpos_d = (flip_d && de_d) ? H_ACT - 1'b1 - h_d : h_d;
    vpos_d = (flip_d && de_d) ? V_ACT - 1'b1 - v_d : v_d;
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flip_q <= 1'b0;
      hpos_q <= H_LAST;
      vpos_q <= V_LAST;
    end else if (CE) begin
      flip_q <= flip_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  assign HPOS = hpos_q;
  assign VPOS = vpos_q;
`else
  assign HPOS = h_q;
  assign VPOS = v_q;
`endif

  assign HBLK        = hblk_q;
  assign VBLK        = vblk_q;
  assign DE          = de_q;
  assign HSYN        = hsyn_q;
  assign VSYN        = vsyn_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
  assign RGB_OUT     = rgb_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// tb/tb_hv_timing_gen.sv - randomized self-checking bench for hv_timing_gen against a position-level model
// Default horizontal timing with a shortened vertical frame; covers HVTG_FLIP_EN when defined.
module tb_hv_timing_gen;

  localparam int HA = 288, HF = 20, HS = 32, HB = 44;
  localparam int VA = 8,   VF = 2,  VS = 3,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        MCLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE = 1'b0;
  logic [11:0] RGB_IN = '0;
`ifdef HVTG_FLIP_EN
  logic        FLIP = 1'b0;
`endif
  logic [8:0]  HPOS, VPOS;
  logic        HBLK, VBLK, DE, HSYN, VSYN, LINE_START, FRAME_START;
  logic [11:0] RGB_OUT;

  hv_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HW(9), .VW(9), .DW(12), .SYNC_POL(0)
  ) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .CE(CE), .RGB_IN(RGB_IN),
`ifdef HVTG_FLIP_EN
    .FLIP(FLIP),
`endif
    .HPOS(HPOS), .VPOS(VPOS), .HBLK(HBLK), .VBLK(VBLK), .DE(DE),
    .HSYN(HSYN), .VSYN(VSYN), .LINE_START(LINE_START), .FRAME_START(FRAME_START),
    .RGB_OUT(RGB_OUT)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int failures = 0;

  int          m_h, m_v;
  logic [11:0] m_rgb;
  bit          m_ls, m_fs, m_flip;

  wire [36:0] obs = {HPOS, VPOS, HBLK, VBLK, DE, HSYN, VSYN, LINE_START, FRAME_START, RGB_OUT};

  function automatic logic [36:0] model_vec();
    bit act;
    int ph, pv;
    act = (m_h < HA) && (m_v < VA);
    ph  = (m_flip && act) ? HA - 1 - m_h : m_h;
    pv  = (m_flip && act) ? VA - 1 - m_v : m_v;
    return {9'(ph), 9'(pv), m_h >= HA, m_v >= VA, act,
            !(m_h >= HA + HF && m_h < HA + HF + HS),
            !(m_v >= VA + VF && m_v < VA + VF + VS),
            m_ls, m_fs, m_rgb};
  endfunction

  task automatic model_reset();
    m_h = HT - 1; m_v = VT - 1; m_rgb = '0; m_ls = 0; m_fs = 0; m_flip = 0;
  endtask

  task automatic step(input bit ce, input logic [11:0] rgb);
    @(negedge MCLK);
    CE = ce;
    RGB_IN = rgb;
    @(posedge MCLK);
    #1;
    m_ls = 0;
    m_fs = 0;
    if (ce) begin
      m_h = (m_h + 1) % HT;
      if (m_h == 0) m_v = (m_v + 1) % VT;
`ifdef HVTG_FLIP_EN
      if (m_h == 0 && m_v == 0) m_flip = FLIP;
`endif
      m_rgb = (m_h < HA && m_v < VA) ? rgb : 12'h000;
      m_ls = (m_h == 0);
      m_fs = (m_h == 0) && (m_v == 0);
    end
  endtask

  task automatic test_reset();
    model_reset();
    RESET_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK);
      CE = 1'b1;
      RGB_IN = 12'($urandom);
      @(posedge MCLK);
      #1;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%h want=%h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_first_ce();
    @(negedge MCLK);
    CE = 1'b0;
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        step(j == 7, 12'($urandom));
        checks++;
        if (obs !== model_vec()) begin
          failures++;
          $display("FAIL first_ce k=%0d j=%0d got=%h want=%h", k, j, obs, model_vec());
        end
      end
      if (k == 0) begin
        checks++;
        if ({HPOS, VPOS, FRAME_START, LINE_START, DE} !== {9'd0, 9'd0, 1'b1, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL first_pixel hpos=%0d vpos=%0d fs=%b ls=%b de=%b want 0 0 1 1 1",
                   HPOS, VPOS, FRAME_START, LINE_START, DE);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int fs_cnt = 0, ls_cnt = 0, since = 0, bad_line = 0;
    int hb_rise = -1, hs_first = -1, hs_len = 0, vs_first = -1, vs_lines = 0;
    int guard = 0;
    logic prev_hblk;
    logic [8:0] nh;
    while (!(m_h == HT - 1 && m_v == VT - 1) && guard < HT * VT) begin
      step(1'b1, 12'($urandom));
      guard++;
    end
    checks++;
    if (guard >= HT * VT) begin
      failures++;
      $display("FAIL frame_align_timeout h=%0d v=%0d", m_h, m_v);
    end
    prev_hblk = HBLK;
    for (int i = 0; i < HT * VT; i++) begin
      nh = 9'((m_h + 1) % HT);
      step(1'b1, {nh[3:0], nh[7:0]});
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL full_frame h=%0d v=%0d got=%h want=%h", m_h, m_v, obs, model_vec());
      end
      since++;
      if (FRAME_START) fs_cnt++;
      if (LINE_START) begin
        if (ls_cnt > 0 && since != HT) bad_line++;
        ls_cnt++;
        since = 0;
        if (!VSYN) begin
          vs_lines++;
          if (vs_first < 0) vs_first = int'(VPOS);
        end
      end
      if (VPOS == 9'd0 && !HSYN) begin
        hs_len++;
        if (hs_first < 0) hs_first = int'(HPOS);
      end
      if (HBLK && !prev_hblk && hb_rise < 0) hb_rise = int'(HPOS);
      prev_hblk = HBLK;
    end
    checks++;
    if (fs_cnt != 1) begin failures++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt); end
    checks++;
    if (ls_cnt != VT) begin failures++; $display("FAIL lines_per_frame got=%0d want=%0d", ls_cnt, VT); end
    checks++;
    if (bad_line != 0) begin failures++; $display("FAIL ce_per_line bad_lines=%0d want=0", bad_line); end
    checks++;
    if (hb_rise != 288) begin failures++; $display("FAIL hblk_rise got=%0d want=288", hb_rise); end
    checks++;
    if (hs_first != 308 || hs_len != 32) begin
      failures++;
      $display("FAIL hsync_window first=%0d len=%0d want 308 32", hs_first, hs_len);
    end
    checks++;
    if (vs_first != VA + VF || vs_lines != VS) begin
      failures++;
      $display("FAIL vsync_window first=%0d lines=%0d want %0d %0d", vs_first, vs_lines, VA + VF, VS);
    end
  endtask

  task automatic test_ce_gaps();
    int ce_since = 0, ls_seen = 0, bad_line = 0, repeats = 0;
    bit ce, prev_ls = 0, prev_fs = 0;
    for (int i = 0; i < 9000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      step(ce, 12'($urandom));
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL ce_gaps i=%0d ce=%b got=%h want=%h", i, ce, obs, model_vec());
      end
      if (ce) ce_since++;
      if ((LINE_START && prev_ls) || (FRAME_START && prev_fs)) repeats++;
      if (LINE_START) begin
        if (ls_seen > 0 && ce_since != HT) bad_line++;
        ls_seen++;
        ce_since = 0;
      end
      prev_ls = LINE_START;
      prev_fs = FRAME_START;
    end
    checks++;
    if (repeats != 0) begin failures++; $display("FAIL pulse_repeat got=%0d want=0", repeats); end
    checks++;
    if (bad_line != 0 || ls_seen < 2) begin
      failures++;
      $display("FAIL gap_line_timing bad=%0d lines=%0d want bad=0", bad_line, ls_seen);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(m_v == 3 && m_h == 149) && guard < 2 * HT * VT) begin
      step(1'b1, 12'($urandom));
      guard++;
    end
    step(1'b1, 12'($urandom));
    checks++;
    if (HPOS !== 9'd150 || VPOS !== 9'd3) begin
      failures++;
      $display("FAIL mid_position hpos=%0d vpos=%0d want 150 3", HPOS, VPOS);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", obs, model_vec());
    end
    @(negedge MCLK);
    CE = 1'b1;
    @(posedge MCLK);
    #1;
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("FAIL reset_over_ce got=%h want=%h", obs, model_vec());
    end
    @(negedge MCLK);
    CE = 1'b0;
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(i != 1, 12'($urandom));
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL post_reset i=%0d got=%h want=%h", i, obs, model_vec());
      end
      if (i == 0) begin
        checks++;
        if ({HPOS, VPOS, FRAME_START, DE} !== {9'd0, 9'd0, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL restart_pixel hpos=%0d vpos=%0d fs=%b de=%b want 0 0 1 1", HPOS, VPOS, FRAME_START, DE);
        end
      end
    end
  endtask

`ifdef HVTG_FLIP_EN
  task automatic test_flip();
    int guard = 0;
    while (!(m_v == 1 && m_h == 0) && guard < 2 * HT * VT) begin
      step(1'b1, 12'($urandom));
      guard++;
    end
    FLIP = 1'b1;
    guard = 0;
    while (!m_fs && guard < 2 * HT * VT) begin
      step(1'b1, 12'($urandom));
      guard++;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL flip_wait h=%0d v=%0d got=%h want=%h", m_h, m_v, obs, model_vec());
      end
    end
    checks++;
    if (HPOS !== 9'(HA - 1) || VPOS !== 9'(VA - 1)) begin
      failures++;
      $display("FAIL flip_origin hpos=%0d vpos=%0d want %0d %0d", HPOS, VPOS, HA - 1, VA - 1);
    end
    while (m_h != 300 && guard < 4 * HT * VT) begin
      step(1'b1, 12'($urandom));
      guard++;
    end
    checks++;
    if (HPOS !== 9'd300) begin
      failures++;
      $display("FAIL flip_raw_blank hpos=%0d want 300", HPOS);
    end
    FLIP = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_first_ce();
    test_full_frame();
    test_ce_gaps();
    test_mid_reset();
`ifdef HVTG_FLIP_EN
    test_flip();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hv_timing_gen.md
HV_TIMING_GEN -- requirements
Module: hv_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 288: visible pixels per line.
REQ-002 SHALL provide parameters H_FP 20, H_SYNC 32, H_BP 44: horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL provide parameters V_ACTIVE 224, V_FP 11, V_SYNC 7, V_BP 22: the same fields for the vertical direction, in lines.
REQ-004 SHALL provide parameters HW 9, VW 9 and DW 12: position counter widths and RGB width.
REQ-005 SHALL provide parameter SYNC_POL, default 0: 0 = active-low syncs, 1 = active-high syncs.
REQ-006 Port MCLK, input, 1: sole clock.
REQ-007 Port RESET_N, input, 1: reset, asynchronous, active-low.
REQ-008 Port CE, input, 1: pixel enable; the block advances one pixel per MCLK cycle with CE=1.
REQ-009 Port RGB_IN, input, DW: pixel data.
REQ-010 Ports HPOS (output, HW) and VPOS (output, VW): current position.
REQ-011 Ports HBLK, VBLK, DE: outputs, 1 bit each.
REQ-012 Ports HSYN, VSYN: outputs, 1 bit each.
REQ-013 Ports LINE_START, FRAME_START: outputs, 1 bit each.
REQ-014 Port RGB_OUT: output, DW.

Function
REQ-015 H_TOTAL = sum of the H parameters and V_TOTAL = sum of the V parameters; elaboration SHALL fail if H_TOTAL > 2^HW or V_TOTAL > 2^VW.
REQ-016 The h counter SHALL increment on each CE and wrap from H_TOTAL-1 to 0.
REQ-017 The v counter SHALL increment only on the CE where h wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-018 All outputs SHALL be registered and SHALL update only on a CE cycle, except the pulses in REQ-022.
REQ-019 HBLK and VBLK are registered with the counter: HBLK=1 iff h >= H_ACTIVE; VBLK=1 iff v >= V_ACTIVE; DE = ~HBLK & ~VBLK.
REQ-020 HSYN SHALL be asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, with the level set by SYNC_POL.
REQ-021 VSYN SHALL be asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, with the level set by SYNC_POL.
REQ-022 LINE_START SHALL be 1 for exactly one MCLK cycle, the cycle in which h becomes 0; FRAME_START likewise for h=0 and v=0.
REQ-023 Both pulses SHALL be 0 on all other cycles, including CE=0 cycles that hold position 0.
REQ-024 RGB_OUT SHALL equal RGB_IN sampled on the CE that set the current HPOS/VPOS, forced to 0 when HBLK|VBLK: one pixel of latency, aligned with the flags.
REQ-025 With CE=0, every output except the pulses SHALL hold its value.
REQ-026 With CE held at 1 continuously, the block SHALL produce one pixel per MCLK with no skipped count.

Reset
REQ-027 While RESET_N=0, outputs SHALL be: h=H_TOTAL-1, v=V_TOTAL-1, HBLK=VBLK=1, DE=0, syncs inactive, pulses 0, RGB_OUT=0.
REQ-028 Reset SHALL take effect immediately without a clock edge, and SHALL override a simultaneous CE.
REQ-029 The first CE after RESET_N rises SHALL produce (0,0) with LINE_START=FRAME_START=1 and DE=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no partial sync pulse extended.

Configuration
REQ-031 With macro HVTG_FLIP_EN defined, the block SHALL add a 1-bit input port FLIP.
REQ-032 FLIP SHALL be sampled only on the FRAME_START cycle and reset to 0.
REQ-033 While the latched FLIP is 1 and the position is active, HPOS SHALL be H_ACTIVE-1-h and VPOS SHALL be V_ACTIVE-1-v.
REQ-034 Outside the active area, and with the latched FLIP at 0, HPOS and VPOS SHALL be raw counts.
REQ-035 Blanks, syncs and pulses SHALL be unaffected by FLIP.
REQ-036 Without HVTG_FLIP_EN, there is no FLIP port and HPOS/VPOS are always raw counts.

Verification
REQ-037 Reset release with default parameters and CE every 8th MCLK -> first CE gives HPOS=0, VPOS=0, FRAME_START one MCLK wide, DE=1.
REQ-038 Run one full frame -> 384 CEs per line and 264 lines per frame; HBLK rises at h=288; HSYN low for h 308..339; VSYN low for v 235..241; exactly one FRAME_START.
REQ-039 RGB_IN=h[7:0] replicated -> RGB_OUT equals previous-CE data within the active area, and 0 at h=288 and at every v>=224.
REQ-040 CE held at 1 with CE gaps inserted at random -> all outputs frozen during gaps, pulses never repeat, and line timing matches the CE count.
REQ-041 RESET_N pulsed low at v=100, h=150, with a CE on the same edge -> outputs take reset values asynchronously, then the REQ-029 sequence follows.
REQ-042 With HVTG_FLIP_EN: FLIP toggled at v=50 -> no change until the next FRAME_START; then HPOS=287 at h=0 and VPOS=223 at v=0, and HPOS=300 raw at h=300.
